// File: rtl/int_arb_pkg.sv
// int_arb register select type and bus address decoder.
// MODE register decodes only when INT_ARB_EDGE_EN is defined.
`include "int_arb.svh"

package int_arb_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PENDING,
    REG_ENABLE,
    REG_THRESH,
    REG_CLAIM,
    REG_MODE,
    REG_PRIO
  } reg_sel_e;

  localparam logic [5:0] W_PENDING = 6'(`INT_ARB__PENDING >> 2);
  localparam logic [5:0] W_ENABLE  = 6'(`INT_ARB__ENABLE >> 2);
  localparam logic [5:0] W_THRESH  = 6'(`INT_ARB__THRESHOLD >> 2);
  localparam logic [5:0] W_CLAIM   = 6'(`INT_ARB__CLAIM >> 2);
  localparam logic [5:0] W_MODE    = 6'(`INT_ARB__MODE >> 2);
  localparam logic [5:0] W_PRIO    = 6'(`INT_ARB__PRIO_BASE >> 2);

  // Decodes a word address (byte address bits 7:2).
  function automatic reg_sel_e reg_decode(input logic [5:0] w);
    reg_sel_e s;
    unique case (1'b1)
      w == W_PENDING: s = REG_PENDING;
      w == W_ENABLE:  s = REG_ENABLE;
      w == W_THRESH:  s = REG_THRESH;
      w == W_CLAIM:   s = REG_CLAIM;
`ifdef INT_ARB_EDGE_EN
      w == W_MODE:    s = REG_MODE;
`endif
      w >= W_PRIO:    s = REG_PRIO;
      default:        s = REG_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/int_arb.svh
// int_arb shared register offsets and ID constants.
`ifndef INT_ARB_SVH
`define INT_ARB_SVH
`define INT_ARB__PENDING   8'h00
`define INT_ARB__ENABLE    8'h04
`define INT_ARB__THRESHOLD 8'h08
`define INT_ARB__CLAIM     8'h0C
`define INT_ARB__MODE      8'h10
`define INT_ARB__PRIO_BASE 8'h40
`define INT_ARB__ID_W      5
`define INT_ARB__ID_NONE   5'd0
`endif

// File: rtl/int_arb_gateway.sv
// int_arb per-source gateway: pending latch and in-service flag.
// INT_ARB_EDGE_EN adds a src_q delay line for edge-triggered mode.
module int_arb_gateway (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic set;

`ifdef INT_ARB_EDGE_EN
  logic [1:0] src_q;

  always_ff @(posedge clk) begin
    if (rst) src_q <= '0;
    else     src_q <= {src_q[0], src};
  end

  // Edges latch even while in service; one-deep.
  assign set = mode ? (src_q[0] & ~src_q[1])
                    : (src & ~pending & ~in_service);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign set = src & ~pending & ~in_service;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      pending    <= (pending & ~claim) | set;
      in_service <= claim | (in_service & ~complete);
    end
  end

endmodule

// File: rtl/int_arb.sv
// int_arb top: registers, priority selection, claim/complete decode.
// Optional edge mode via INT_ARB_EDGE_EN.
`include "int_arb.svh"

module int_arb
  import int_arb_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src,
  input  logic [7:0]               addr,
  input  logic                     re,
  input  logic                     we,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     exti,
  output logic [`INT_ARB__ID_W-1:0] irq_id
);

  logic [NSRC-1:0]   enable;
  logic [NSRC-1:0]   mode;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   in_service;
  logic [NSRC-1:0]   claim;
  logic [NSRC-1:0]   complete;
  logic [PRIO_W-1:0] threshold;
  logic [PRIO_W-1:0] prio [NSRC];

  reg_sel_e   sel;
  logic [5:0] pidx;
  logic       prio_hit;
  logic       rd_claim;
  logic       wr_claim;

  assign sel      = reg_decode(addr[7:2]);
  assign pidx     = addr[7:2] - W_PRIO;
  assign prio_hit = (sel == REG_PRIO) && (pidx < 6'(NSRC));
  assign rd_claim = re && (sel == REG_CLAIM);
  assign wr_claim = we && (sel == REG_CLAIM);

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

  // Winner: strictly above threshold, first index keeps ties.
  logic [PRIO_W-1:0]         best;
  logic [`INT_ARB__ID_W-1:0] win;

  always_comb begin
    best = threshold;
    win  = `INT_ARB__ID_NONE;
    for (int i = 0; i < NSRC; i++) begin
      if (pending[i] && enable[i] && !in_service[i]
          && prio[i] > best) begin
        best = prio[i];
        win  = 5'(i + 1);
      end
    end
  end

  always_comb begin
    claim    = '0;
    complete = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim[i]    = rd_claim && (win == 5'(i + 1));
      complete[i] = wr_claim && (wdata[4:0] == 5'(i + 1));
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_gw
    int_arb_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .src        (src[g]),
      .mode       (mode[g]),
      .claim      (claim[g]),
      .complete   (complete[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      threshold <= '0;
      for (int i = 0; i < NSRC; i++) prio[i] <= '0;
    end else if (we) begin
      case (sel)
        REG_ENABLE: enable    <= wdata[NSRC-1:0];
        REG_THRESH: threshold <= wdata[PRIO_W-1:0];
        REG_PRIO: begin
          for (int i = 0; i < NSRC; i++)
            if (prio_hit && pidx == 6'(i))
              prio[i] <= wdata[PRIO_W-1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef INT_ARB_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst)                      mode <= '0;
    else if (we && sel == REG_MODE) mode <= wdata[NSRC-1:0];
  end
`else
  assign mode = '0;
`endif

  logic [PRIO_W-1:0] prio_rd;
  logic [31:0]       rval;

  always_comb begin
    prio_rd = '0;
    for (int i = 0; i < NSRC; i++)
      if (pidx == 6'(i)) prio_rd = prio[i];
  end

  always_comb begin
    rval = '0;
    case (sel)
      REG_PENDING: rval = 32'(pending);
      REG_ENABLE:  rval = 32'(enable);
      REG_THRESH:  rval = 32'(threshold);
      REG_CLAIM:   rval = 32'(win);
      REG_MODE:    rval = 32'(mode);
      REG_PRIO:    rval = prio_hit ? 32'(prio_rd) : '0;
      default:     rval = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      exti   <= 1'b0;
      irq_id <= `INT_ARB__ID_NONE;
    end else begin
      rdata  <= re ? rval : '0;
      exti   <= (win != `INT_ARB__ID_NONE);
      irq_id <= win;
    end
  end

endmodule

// File: tb/tb_int_arb.sv
// tb_int_arb: directed and random checks against a behavioural model.
// Edge-mode steps run only when INT_ARB_EDGE_EN is defined.
module tb_int_arb;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic [7:0]      addr = '0;
  logic            re = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            exti;
  logic [4:0]      irq_id;

  int n_chk = 0;
  int n_fail = 0;

  bit [NSRC-1:0] m_pend, m_svc, m_en, m_mode, m_src;
  int m_thr;
  int m_prio [NSRC];

  int_arb #(.NSRC(NSRC), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .src(src), .addr(addr),
    .re(re), .we(we), .wdata(wdata), .rdata(rdata),
    .exti(exti), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Eligible set, then the highest priority, then the lowest index.
  function automatic int model_win();
    int top;
    top = -1;
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_en[i] && !m_svc[i] && m_prio[i] > m_thr)
        if (m_prio[i] > top) top = m_prio[i];
    if (top < 0) return 0;
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_en[i] && !m_svc[i] && m_prio[i] == top)
        return i + 1;
    return 0;
  endfunction

  function automatic void settle();
    for (int i = 0; i < NSRC; i++)
      if (!m_mode[i] && m_src[i] && !m_svc[i]) m_pend[i] = 1'b1;
  endfunction

  function automatic void model_reset();
    m_pend = '0; m_svc = '0; m_en = '0; m_mode = '0; m_src = '0;
    m_thr = 0;
    for (int i = 0; i < NSRC; i++) m_prio[i] = 0;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    cyc();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_write(a, d);
    if (a == 8'h04) m_en = d[NSRC-1:0];
    if (a == 8'h08) m_thr = int'(d[2:0]);
`ifdef INT_ARB_EDGE_EN
    if (a == 8'h10) m_mode = d[NSRC-1:0];
`endif
    if (a >= 8'h40 && a < 8'h40 + 8'(4 * NSRC) && a[1:0] == 2'b0)
      m_prio[(a - 8'h40) >> 2] = int'(d[2:0]);
    idle(3);
    settle();
  endtask

  task automatic set_src(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++)
      if (m_mode[i] && v[i] && !m_src[i]) m_pend[i] = 1'b1;
    m_src = v;
    src = v;
    idle(3);
    settle();
  endtask

  task automatic do_claim(input string tag);
    logic [31:0] d;
    int w;
    w = model_win();
    bus_read(8'h0C, d);
    check(tag, d, 32'(w));
    if (w != 0) begin
      m_pend[w-1] = 1'b0;
      m_svc[w-1]  = 1'b1;
    end
    idle(3);
    settle();
  endtask

  task automatic do_complete(input int id);
    bus_write(8'h0C, 32'(id));
    if (id >= 1 && id <= NSRC && m_svc[id-1]) m_svc[id-1] = 1'b0;
    idle(3);
    settle();
  endtask

  task automatic check_out(input string tag);
    int w;
    w = model_win();
    check({tag, "_irq"}, 32'(irq_id), 32'(w));
    check({tag, "_exti"}, 32'(exti), 32'(w != 0));
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] d;
    bus_read(8'h00, d); check({tag, "_pend"}, d, 32'(m_pend));
    bus_read(8'h04, d); check({tag, "_en"}, d, 32'(m_en));
    bus_read(8'h08, d); check({tag, "_thr"}, d, 32'(m_thr));
    bus_read(8'h10, d); check({tag, "_mode"}, d, 32'(m_mode));
    bus_read(8'h20, d); check({tag, "_unmap"}, d, 32'h0);
    for (int i = 0; i < NSRC; i++) begin
      bus_read(8'h40 + 8'(4 * i), d);
      check({tag, "_prio"}, d, 32'(m_prio[i]));
    end
  endtask

  initial begin
    logic [31:0] d;
    int q [$];
    model_reset();
    idle(3);
    rst = 1'b0;
    cyc();
    check("rst_exti", 32'(exti), 32'h0);
    check("rst_irq", 32'(irq_id), 32'h0);
    check_reads("rst");
    do_claim("rst_claim");

    // Equal priorities: lowest index wins.
    wr(8'h48, 5); wr(8'h50, 5); wr(8'h04, 32'h14); wr(8'h08, 2);
    set_src(8'h14);
    check("tie_irq", 32'(irq_id), 32'd3);
    check_out("tie");
    do_claim("tie_claim3");
    check("tie_next", 32'(irq_id), 32'd5);
    do_claim("tie_claim5");
    check_out("tie_none");
    set_src(8'h00);
    do_complete(3); do_complete(5);
    check_out("tie_done");

    // Threshold masking and exact write-to-exti latency.
    wr(8'h08, 5);
    set_src(8'h04); set_src(8'h00);
    check("thr_mask", 32'(exti), 32'h0);
    bus_write(8'h08, 4);
    m_thr = 4;
    check("thr_lat1", 32'(exti), 32'h0);
    cyc();
    check("thr_lat2", 32'(exti), 32'h1);
    idle(2);
    do_claim("thr_claim");
    do_complete(3);

    // Level source held high across claim/complete.
    wr(8'h40, 1); wr(8'h04, 32'h01); wr(8'h08, 0);
    set_src(8'h01);
    check_out("lvl_up");
    do_claim("lvl_claim");
    check("lvl_drop", 32'(exti), 32'h0);
    do_complete(1);
    check("lvl_back", 32'(exti), 32'h1);
    do_complete(7); do_complete(0); do_complete(9);
    check_out("lvl_ign");

`ifdef INT_ARB_EDGE_EN
    set_src(8'h00);
    do_claim("edge_pre");
    do_complete(1);
    wr(8'h10, 32'h01);
    set_src(8'h01); set_src(8'h00);
    do_claim("edge_claim");
    set_src(8'h01); set_src(8'h00);
    bus_read(8'h00, d);
    check("edge_pend", d, 32'h1);
    check("edge_exti0", 32'(exti), 32'h0);
    do_complete(1);
    check("edge_exti1", 32'(exti), 32'h1);
    check_out("edge");
`endif

    // Read and write in the same cycle return the old value.
    addr = 8'h08; wdata = 32'h6; re = 1'b1; we = 1'b1;
    cyc();
    re = 1'b0; we = 1'b0;
    check("rw_old", rdata, 32'(m_thr));
    m_thr = 6;
    idle(3);
    bus_read(8'h08, d);
    check("rw_new", d, 32'h6);
    wr(8'h08, 0);

    // Reset while a source is in service.
    wr(8'h04, 32'h05);
    set_src(m_src | 8'h04);
    do_claim("pre_rst");
    rst = 1'b1;
    cyc();
    check("rst2_exti", 32'(exti), 32'h0);
    check("rst2_irq", 32'(irq_id), 32'h0);
    src = '0;
    model_reset();
    rst = 1'b0;
    cyc();
    check_reads("rst2");

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: set_src(NSRC'($urandom));
        1: begin
          wr(8'h04, $urandom);
          bus_read(8'h04, d);
          check("rnd_en", d, 32'(m_en));
        end
        2: wr(8'h40 + 8'(4 * $urandom_range(0, NSRC - 1)),
              $urandom_range(0, 7));
        3: wr(8'h08, $urandom_range(0, 4));
        4: do_claim("rnd_claim");
        default: begin
          q.delete();
          for (int i = 0; i < NSRC; i++) if (m_svc[i]) q.push_back(i + 1);
          if (q.size() > 0 && $urandom_range(0, 1) == 1)
            do_complete(q[$urandom_range(0, q.size() - 1)]);
          else
            do_complete($urandom_range(0, 9));
        end
      endcase
      check_out("rnd");
      bus_read(8'h00, d);
      check("rnd_pend", d, 32'(m_pend));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
